// File: rtl/fp16_pkg.sv
// Shared half-precision definitions for the FPU datapath blocks:
// field widths, special encodings, FSM state type and field extractors.
package fp16_pkg;

    localparam int NEXP    = 5;
    localparam int NSIG    = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = (1 << NEXP) - 1;
    localparam int NWORD   = NEXP + NSIG + 1;
    localparam int CNT_W   = $clog2(NSIG + 2);

    typedef logic [NWORD-1:0] fp16_t;

    localparam fp16_t FP16_PINF = {1'b0, {NEXP{1'b1}}, {NSIG{1'b0}}};
    localparam fp16_t FP16_NINF = {1'b1, {NEXP{1'b1}}, {NSIG{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_NORM,
        ST_DONE
    } state_t;

    function automatic logic fp_sign(input fp16_t x);
        return x[NWORD-1];
    endfunction

    function automatic logic [NEXP-1:0] fp_exp(input fp16_t x);
        return x[NWORD-2:NSIG];
    endfunction

    function automatic logic [NSIG-1:0] fp_frac(input fp16_t x);
        return x[NSIG-1:0];
    endfunction

endpackage

// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle between the FPU pipeline and the multiplier.
interface fp_mul_seq_if;
    import fp16_pkg::*;

    logic  in_valid;
    logic  in_ready;
    fp16_t a;
    fp16_t b;
    logic  out_valid;
    logic  out_ready;
    fp16_t p;
    logic  busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );

endinterface

// File: rtl/sig_mul_iter.sv
// Shift-add significand multiplier: one partial product per cycle, NSIG+1 cycles.
// done marks the cycle in which the final partial product is being added.
module sig_mul_iter
    import fp16_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NSIG:0]           mcand_in,
    input  logic [NSIG:0]           mplier_in,
    output logic                    done,
    output logic [2*(NSIG+1)-1:0]   prod
);

    logic [2*(NSIG+1)-1:0] mcand;
    logic [2*(NSIG+1)-1:0] acc;
    logic [NSIG:0]         mplier;
    logic [CNT_W-1:0]      cnt;
    logic                  running;

    assign done = running && (cnt == CNT_W'(NSIG));
    assign prod = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= {{(NSIG+1){1'b0}}, mcand_in};
            mplier  <= mplier_in;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential truncating fp16 multiplier: FSM, sign/exponent/special-case path
// around the iterative significand core, with a registered result.
module fp_mul_seq
    import fp16_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fp_mul_seq_if.slave  bus
);

    state_t                  state;
    logic                    sign_r;
    logic                    zero_r;
    logic                    inf_r;
    logic [NEXP+1:0]         esum_r;
    logic                    start;
    logic                    core_done;
    logic [2*(NSIG+1)-1:0]   prod;
    logic [NEXP+1:0]         e_norm;
    logic [NSIG-1:0]         frac_norm;
    logic                    ovf;
    logic                    unf;

    assign start = (state == ST_IDLE) && bus.in_valid && bus.in_ready;

    sig_mul_iter u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mcand_in  ({1'b1, fp_frac(bus.a)}),
        .mplier_in ({1'b1, fp_frac(bus.b)}),
        .done      (core_done),
        .prod      (prod)
    );

    // A product in [2,4) carries into the top bit and bumps the exponent.
    always_comb begin
        e_norm    = esum_r;
        frac_norm = prod[2*NSIG-1:NSIG];
        if (prod[2*NSIG+1]) begin
            e_norm    = esum_r + 1'b1;
            frac_norm = prod[2*NSIG:NSIG+1];
        end
    end

    assign ovf = !e_norm[NEXP+1] && (e_norm[NEXP:0] >= (NEXP+1)'(EXP_MAX));
    assign unf = e_norm[NEXP+1] || (e_norm == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.p         <= '0;
            bus.busy      <= 1'b0;
            sign_r        <= 1'b0;
            zero_r        <= 1'b0;
            inf_r         <= 1'b0;
            esum_r        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sign_r       <= fp_sign(bus.a) ^ fp_sign(bus.b);
                        zero_r       <= (fp_exp(bus.a) == '0) || (fp_exp(bus.b) == '0);
                        inf_r        <= (fp_exp(bus.a) == NEXP'(EXP_MAX)) ||
                                        (fp_exp(bus.b) == NEXP'(EXP_MAX));
                        esum_r       <= {2'b00, fp_exp(bus.a)} + {2'b00, fp_exp(bus.b)}
                                        - (NEXP+2)'(BIAS);
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (core_done) begin
                        state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    // Zero wins over infinity, so inf x 0 yields a signed zero.
                    if (zero_r || (!inf_r && unf)) begin
                        bus.p <= {sign_r, {(NWORD-1){1'b0}}};
                    end else if (inf_r || ovf) begin
                        bus.p <= sign_r ? FP16_NINF : FP16_PINF;
                    end else begin
                        bus.p <= {sign_r, e_norm[NEXP-1:0], frac_norm};
                    end
                    bus.out_valid <= 1'b1;
                    state         <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed self-checking bench for fp_mul_seq: hand-computed fp16 products,
// latency, backpressure, mid-operation reset and back-to-back throughput.
module tb_fp_mul_seq;
    import fp16_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    fp_mul_seq_if bus ();

    fp_mul_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair while idle; returns just after the accept edge.
    task automatic applyStimulus(input string tag, input fp16_t ta, input fp16_t tb2);
        checkOutput({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a        = ta;
        bus.b        = tb2;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Edges counted from the accept edge (inclusive) to the edge raising out_valid.
    task automatic waitResult(input string tag, output int lat);
        lat = 1;
        for (int i = 0; i < 40 && !bus.out_valid; i++) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic runVector(input string tag, input fp16_t ta, input fp16_t tb2, input fp16_t want);
        int lat;
        applyStimulus(tag, ta, tb2);
        waitResult(tag, lat);
        checkOutput({tag, "_p"}, 32'(bus.p), 32'(want));
        checkOutput({tag, "_lat"}, 32'(lat), 32'd13);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput({tag, "_vlow"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int    lat;
        logic  stable;
        int    edgeNo;
        int    accepts;
        int    results;
        int    accEdge [2];
        int    hsEdge  [2];
        fp16_t rp      [2];
        logic  accNow;
        logic  hsNow;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_p",         32'(bus.p),         32'd0);
        checkOutput("rst_busy",      32'(bus.busy),      32'd0);
        rst = 1'b0;
        tick();

        runVector("neg10x5",   16'hC900, 16'h4500, 16'hD240);
        runVector("norm_up",   16'h3E00, 16'h3E00, 16'h4080);
        runVector("two_x3",    16'h4000, 16'h4200, 16'h4600);
        runVector("negneg",    16'hC000, 16'hC200, 16'h4600);
        runVector("one_x1",    16'h3C00, 16'h3C00, 16'h3C00);
        runVector("trunc",     16'h3C01, 16'h3C01, 16'h3C02);
        runVector("overflow",  16'h7800, 16'h4000, 16'h7C00);
        runVector("underflow", 16'h0400, 16'h3800, 16'h0000);
        runVector("sgn_zero",  16'h8000, 16'h4200, 16'h8000);
        runVector("neg_inf",   16'hFC00, 16'h4000, 16'hFC00);
        runVector("inf_x0",    16'h7C00, 16'h8000, 16'h8000);

        $display("[TB] backpressure");
        applyStimulus("bp", 16'h3E00, 16'h3E00);
        waitResult("bp", lat);
        checkOutput("bp_p", 32'(bus.p), 32'h4080);
        bus.a        = 16'h4000;
        bus.b        = 16'h4200;
        bus.in_valid = 1'b1;
        stable       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.p !== 16'h4080 || bus.out_valid !== 1'b1 ||
                bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                stable = 1'b0;
            end
        end
        checkOutput("bp_stable", 32'(stable), 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("bp_rel_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("bp_rel_ready", 32'(bus.in_ready),  32'd1);
        checkOutput("bp_rel_busy",  32'(bus.busy),      32'd0);

        $display("[TB] reset mid-MUL");
        applyStimulus("rstmid", 16'hC900, 16'h4500);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstmid_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rstmid_ready", 32'(bus.in_ready),  32'd1);
        checkOutput("rstmid_p",     32'(bus.p),         32'd0);
        stable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) stable = 1'b0;
        end
        checkOutput("rstmid_no_stale", 32'(stable), 32'd1);
        runVector("rstmid_fresh", 16'h4000, 16'h4200, 16'h4600);

        $display("[TB] back-to-back");
        edgeNo  = 0;
        accepts = 0;
        results = 0;
        accEdge = '{0, 0};
        hsEdge  = '{0, 0};
        rp      = '{16'h0, 16'h0};
        bus.a         = 16'h4000;
        bus.b         = 16'h4200;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 80 && results < 2; c++) begin
            accNow = bus.in_valid && bus.in_ready;
            hsNow  = bus.out_valid && bus.out_ready;
            if (hsNow && results < 2) rp[results] = bus.p;
            tick();
            edgeNo++;
            if (accNow && accepts < 2) begin
                accEdge[accepts] = edgeNo;
                accepts++;
                if (accepts == 1) begin
                    bus.a = 16'hC900;
                    bus.b = 16'h4500;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (hsNow && results < 2) begin
                hsEdge[results] = edgeNo;
                results++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        checkOutput("b2b_results", 32'(results), 32'd2);
        checkOutput("b2b_accepts", 32'(accepts), 32'd2);
        checkOutput("b2b_p0",      32'(rp[0]),   32'h4600);
        checkOutput("b2b_p1",      32'(rp[1]),   32'hD240);
        checkOutput("b2b_period",  32'(hsEdge[0] - accEdge[0]), 32'd13);
        checkOutput("b2b_reaccept", 32'(accEdge[1] - hsEdge[0]), 32'd1);
        checkOutput("b2b_idle",    32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
